// File: rtl/booth_pkg.sv
// Shared types and Booth digit encodings for the radix-4 Booth multiplier family.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit selects packed as {neg, two, one}.
    localparam logic [2:0] PP_ZERO = 3'b000;
    localparam logic [2:0] PP_POS1 = 3'b001;
    localparam logic [2:0] PP_POS2 = 3'b010;
    localparam logic [2:0] PP_NEG1 = 3'b101;
    localparam logic [2:0] PP_NEG2 = 3'b110;

endpackage

// File: rtl/booth_r4_seq_mult_if.sv
// Operand/result handshake bundle for the sequential Booth multiplier.
interface booth_r4_seq_mult_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic                 sgn;
    logic                 busy;
    logic                 ready;
    logic [2*WIDTH-1:0]   out;
    logic                 get;

    modport master (
        output start, a_in, b_in, sgn, get,
        input  busy, ready, out
    );

    modport slave (
        input  start, a_in, b_in, sgn, get,
        output busy, ready, out
    );
endinterface

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth digit encoder: maps a multiplier bit triplet onto neg/one/two selects.
module booth_r4_digit_enc
    import booth_pkg::*;
(
    input  logic [2:0] triplet,
    output logic       neg,
    output logic       one,
    output logic       two
);

    logic [2:0] sel;

    always_comb begin
        sel = PP_ZERO;
        case (triplet)
            3'b000, 3'b111: sel = PP_ZERO;
            3'b001, 3'b010: sel = PP_POS1;
            3'b011:         sel = PP_POS2;
            3'b100:         sel = PP_NEG2;
            3'b101, 3'b110: sel = PP_NEG1;
            default:        sel = PP_ZERO;
        endcase
    end

    assign neg = sel[2];
    assign two = sel[1];
    assign one = sel[0];

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one digit per clock, signed or unsigned per operation,
// product held on out until the consumer acknowledges it with get.
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input logic               clk,
    input logic               rst,
    booth_r4_seq_mult_if.slave bus
);

    localparam int NDIG = WIDTH / 2;
    localparam int AW   = 2 * WIDTH + 4;
    localparam int PW   = WIDTH + 3;
    localparam int CW   = $clog2(NDIG + 2);

    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_width_check
        $error("booth_r4_seq_mult: WIDTH must be even and >= 4");
    end

    state_t               state;
    state_t               state_next;
    logic [WIDTH+1:0]     a_reg;
    logic [WIDTH+2:0]     b_reg;
    logic [AW-1:0]        acc;
    logic [AW-1:0]        acc_next;
    logic [CW-1:0]        dig_cnt;
    logic [CW-1:0]        n_iter;
    logic [2*WIDTH-1:0]   out_reg;
    logic [PW-1:0]        pp_mag;
    logic [PW-1:0]        pp;
    logic [AW-1:0]        pp_ext;
    logic                 neg;
    logic                 one;
    logic                 two;
    logic                 last_digit;
    logic                 busy;
    logic                 ready;

    booth_r4_digit_enc u_enc (
        .triplet (b_reg[2:0]),
        .neg     (neg),
        .one     (one),
        .two     (two)
    );

    // Partial product is formed in WIDTH+3 bits so that 2A never overflows before sign extension.
    always_comb begin
        pp_mag = '0;
        if (two) begin
            pp_mag = {a_reg, 1'b0};
        end else if (one) begin
            pp_mag = {a_reg[WIDTH+1], a_reg};
        end
        pp       = neg ? (~pp_mag + PW'(1)) : pp_mag;
        pp_ext   = {{(AW-PW){pp[PW-1]}}, pp};
        acc_next = acc + (pp_ext << {dig_cnt, 1'b0});
    end

    assign last_digit = (dig_cnt == (n_iter - CW'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (last_digit) state_next = DONE;
            DONE:    if (bus.get)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == CALC);
        ready = (state == DONE);
    end

    // Unsigned operands need one extra digit so the zero-extended top bits are consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            dig_cnt <= '0;
            n_iter  <= '0;
            out_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg   <= bus.sgn ? {{2{bus.a_in[WIDTH-1]}}, bus.a_in}
                                           : {2'b00, bus.a_in};
                        b_reg   <= bus.sgn ? {{2{bus.b_in[WIDTH-1]}}, bus.b_in, 1'b0}
                                           : {2'b00, bus.b_in, 1'b0};
                        acc     <= '0;
                        dig_cnt <= '0;
                        n_iter  <= bus.sgn ? CW'(NDIG) : CW'(NDIG + 1);
                    end
                end
                CALC: begin
                    acc     <= acc_next;
                    b_reg   <= {{2{b_reg[WIDTH+2]}}, b_reg[WIDTH+2:2]};
                    dig_cnt <= dig_cnt + CW'(1);
                    if (last_digit) begin
                        out_reg <= acc_next[2*WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = busy;
    assign bus.ready = ready;
    assign bus.out   = out_reg;

endmodule

// File: doc/booth_r4_seq_mult.md
Name: booth_r4_seq_mult

Overview:
Parametrised sequential radix-4 Booth multiplier, successor to the fixed 8-bit Booth block. Takes WIDTH-bit operands in one transfer, with per-operation signed or unsigned mode. Retires one Booth digit (two multiplier bits) per clock. Holds the 2*WIDTH-bit product until the consumer acknowledges it, using the existing start / ready / get handshake style.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4 (elaboration error otherwise).
NDIG, WIDTH/2, derived number of Booth digits; localparam, not overridable.

Ports:
clk    input   1          rising-edge clock
rst    input   1          asynchronous, active-low reset (0 = reset)
start  input   1          request; sampled only in IDLE
a_in   input   WIDTH      multiplicand, latched when start is accepted
b_in   input   WIDTH      multiplier, latched when start is accepted
sgn    input   1          1 = two's-complement operands, 0 = unsigned; latched with operands
busy   output  1          1 in CALC
ready  output  1          1 in DONE; product valid on out
out    output  2*WIDTH    product; held stable while ready=1
get    input   1          consumer acknowledge of the product; sampled only in DONE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, ready=0, out=0, all internal registers 0. Reset mid-CALC or mid-DONE abandons the operation; no partial result is exposed.
- States: IDLE, CALC, DONE.
  - IDLE -> CALC on start=1.
  - CALC -> DONE after the last digit.
  - DONE -> IDLE on get=1.
  - No other transitions.
- Load (start accepted in IDLE):
  - Multiplicand register A (WIDTH+2 bits) = a_in, sign-extended when sgn=1, zero-extended when sgn=0.
  - Multiplier register B (WIDTH+3 bits) = {ext2, b_in, 1'b0}, where ext2 is the sign bit replicated (sgn=1) or 2'b00 (sgn=0).
  - Accumulator ACC (2*WIDTH+4 bits) = 0.
  - Digit counter = 0; iteration count N = NDIG if sgn=1, else NDIG+1.
- CALC, one digit per clock:
  - Triplet {B[2],B[1],B[0]} selects the partial product:
    - 000, 111 -> 0
    - 001, 010 -> +A
    - 011 -> +2A
    - 100 -> -2A
    - 101, 110 -> -A
  - The partial product is sign-extended and added into ACC at bit offset 2*digit.
  - B shifts right by 2 (arithmetic); the counter increments.
  - All arithmetic is modulo 2^(2*WIDTH+4).
- Completion:
  - The clock edge that performs the N-th digit also loads out = ACC_final[2*WIDTH-1:0] and enters DONE.
  - Latency: ready rises N clock edges after the edge that accepted start. For WIDTH=8 that is 4 edges signed, 5 unsigned.
- DONE:
  - ready=1, out held; remains indefinitely until get=1.
  - On the next edge, state=IDLE and ready=0. out keeps its last value until the next completion.
- start in CALC or DONE is ignored and not queued.
- start=1 and get=1 in the same DONE cycle: go to IDLE only. start must be re-asserted in IDLE.
- Operand inputs a_in, b_in and sgn are don't-care outside the accepting edge. Changing them during CALC must not affect the result.
- get in IDLE or CALC is ignored.
- Overflow cannot occur; the product always fits in 2*WIDTH bits for both modes.

Decomposition:
- Shared package booth_pkg:
  - state enum (IDLE, CALC, DONE)
  - Booth digit encoding constants (PP_ZERO, PP_POS1, PP_POS2, PP_NEG1, PP_NEG2)
- One natural sub-module, booth_r4_digit_enc:
  - Input: 3-bit triplet.
  - Outputs: neg, one, two select bits.
  - Purely combinational; reused by future array or pipelined variants.
- Datapath adder and FSM stay in the top module.

Test Plan:
- WIDTH=8, sgn=1, a_in=8'b00001000 (8), b_in=8'b11111001 (-7), start for one cycle -> busy for 4 cycles; ready rises 4 edges after accept; out=16'hFFC8 (-56), held until get=1, then ready=0 next edge.
- WIDTH=8, sgn=0, a_in=8'hFF, b_in=8'hFF -> latency 5 edges; out=16'hFE01. Same operands with sgn=1 -> out=16'h0001.
- WIDTH=8, sgn=1, a_in=8'h80, b_in=8'h80 -> out=16'h4000. Then a_in=8'h80, b_in=8'h7F -> out=16'hC080.
- WIDTH=16, sgn=1, a_in=16'h8000, b_in=16'h7FFF -> ready after 8 edges; out=32'hC0008000.
- Handshake: pulse start again during CALC with different operands -> ignored, result matches first operands. Hold ready 10 cycles without get -> out stable. Assert start and get together in DONE -> returns to IDLE and no new operation starts.
- Reset: drive rst=0 asynchronously (between clock edges) on the 2nd CALC cycle -> busy=0, ready=0, out=0 immediately. After release, a fresh 3*5 (sgn=0) -> out=16'h000F.
